// File: rtl/fpadd_pkg.sv
// Shared definitions for the floating-point adder datapath.
package fpadd_pkg;

  // Shift mode encodings; 2'b11 is reserved and behaves like SHIFT_RLOG.
  typedef enum logic [1:0] {
    SHIFT_RLOG = 2'b00,
    SHIFT_RARI = 2'b01,
    SHIFT_LLOG = 2'b10
  } shift_mode_e;

  // Default mantissa width of the adder.
  localparam int unsigned MANT_W = 11;

endpackage

// File: rtl/shift_stage.sv
// One alignment-shifter layer (shift by 2^K) plus its pipeline register.
module shift_stage
  import fpadd_pkg::*;
#(
  parameter int unsigned WIDTH   = MANT_W,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned K       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               valid_in,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               lost_in,
  input  logic               sign_in,
  input  logic [1:0]         mode_in,
  input  logic [SHAMT_W-1:0] diff_in,
  output logic               valid_out,
  output logic [WIDTH-1:0]   data_out,
  output logic               lost_out,
  output logic               sign_out,
  output logic [1:0]         mode_out,
  output logic [SHAMT_W-1:0] diff_out
);

  localparam int unsigned S = 1 << K;
  // Bits discarded by this layer; a shift wider than the word drops all of it.
  localparam int unsigned LOST_N = (S < WIDTH) ? S : WIDTH;

  logic             fill;
  logic [WIDTH-1:0] layer_data;
  logic             layer_lost;

  // Shift layer: pass through, or shift by S and fold discarded bits into lost.
  always_comb begin
    fill       = (mode_in == SHIFT_RARI) & sign_in;
    layer_data = data_in;
    layer_lost = lost_in;
    if (diff_in[K]) begin
      if (mode_in == SHIFT_LLOG) begin
        layer_data = data_in << S;
        layer_lost = lost_in | (|data_in[WIDTH-1 -: LOST_N]);
      end else begin
        // Vacated top bits take the fill value (sign for arithmetic, else 0).
        layer_data = (data_in >> S) | (fill ? ~({WIDTH{1'b1}} >> S) : '0);
        layer_lost = lost_in | (|data_in[LOST_N-1:0]);
      end
    end
  end

  // Stage register: advances with the whole pipe, holds on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      lost_out  <= 1'b0;
      sign_out  <= 1'b0;
      mode_out  <= 2'b00;
      diff_out  <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      data_out  <= layer_data;
      lost_out  <= layer_lost;
      sign_out  <= sign_in;
      mode_out  <= mode_in;
      diff_out  <= diff_in;
    end
  end

endmodule

// File: rtl/align_shifter_pipe.sv
// Pipelined alignment shifter: one registered layer per shift-amount bit,
// valid/ready handshake with whole-pipe stall on backpressure.
module align_shifter_pipe
  import fpadd_pkg::*;
#(
  parameter int unsigned WIDTH   = MANT_W,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   inp,
  input  logic [SHAMT_W-1:0] diff,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   shifted_num,
  output logic               lost
);

  // Index 0 is the input side; index k+1 is the register of stage k.
  logic               v_s  [SHAMT_W+1];
  logic [WIDTH-1:0]   d_s  [SHAMT_W+1];
  logic               l_s  [SHAMT_W+1];
  logic               sg_s [SHAMT_W+1];
  logic [1:0]         m_s  [SHAMT_W+1];
  logic [SHAMT_W-1:0] df_s [SHAMT_W+1];

  logic stall;

  assign v_s[0]  = in_valid;
  assign d_s[0]  = inp;
  assign l_s[0]  = 1'b0;
  assign sg_s[0] = inp[WIDTH-1];
  assign m_s[0]  = mode;
  assign df_s[0] = diff;

  // Handshake: the pipe only stalls when the result is held by the consumer.
  always_comb begin
    stall    = out_valid & ~out_ready;
    in_ready = ~stall;
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .K       (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (in_ready),
      .valid_in  (v_s[k]),
      .data_in   (d_s[k]),
      .lost_in   (l_s[k]),
      .sign_in   (sg_s[k]),
      .mode_in   (m_s[k]),
      .diff_in   (df_s[k]),
      .valid_out (v_s[k+1]),
      .data_out  (d_s[k+1]),
      .lost_out  (l_s[k+1]),
      .sign_out  (sg_s[k+1]),
      .mode_out  (m_s[k+1]),
      .diff_out  (df_s[k+1])
    );
  end

  assign out_valid   = v_s[SHAMT_W];
  assign shifted_num = d_s[SHAMT_W];
  assign lost        = l_s[SHAMT_W];

endmodule

// File: tb/tb_align_shifter_pipe.sv
// Self-checking bench for align_shifter_pipe (WIDTH=11, SHAMT_W=5).
module tb_align_shifter_pipe;

  localparam int W  = 11;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid, in_ready, out_valid, out_ready, lost;
  logic [W-1:0]  inp, shifted_num;
  logic [SW-1:0] diff;
  logic [1:0]    mode;

  int checks = 0;
  int errs   = 0;
  int n_out  = 0;

  logic [W:0]   exp_q [$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_num;
  logic         prev_lost;

  align_shifter_pipe #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inp         (inp),
    .diff        (diff),
    .mode        (mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .shifted_num (shifted_num),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  // Reference: direct shift by the full amount, lost = OR of dropped input bits.
  function automatic logic [W:0] model(logic [W-1:0] a, logic [SW-1:0] sh, logic [1:0] md);
    logic [W-1:0] r;
    logic         l;
    logic         fill;
    int           s;
    s    = int'(sh);
    fill = (md == 2'b01) ? a[W-1] : 1'b0;
    l    = 1'b0;
    r    = '0;
    for (int i = 0; i < W; i++) begin
      if (md == 2'b10) begin
        if (i >= s) r[i] = a[i-s];
        if (i + s >= W) l = l | a[i];
      end else begin
        r[i] = (i + s < W) ? a[i+s] : fill;
        if (i < s) l = l | a[i];
      end
    end
    return {l, r};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: push model result on accept, compare every valid output cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("frozen_valid", 32'(out_valid), 32'd1);
        chk("frozen_num", 32'(shifted_num), 32'(prev_num));
        chk("frozen_lost", 32'(lost), 32'(prev_lost));
      end
      chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_output: got num %0h with no beat outstanding", shifted_num);
        end else begin
          chk("out_num", 32'(shifted_num), 32'(exp_q[0][W-1:0]));
          chk("out_lost", 32'(lost), 32'(exp_q[0][W]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(inp, diff, mode));
      prev_stall = out_valid && !out_ready;
      prev_num   = shifted_num;
      prev_lost  = lost;
    end
  end

  // Present a beat and return just after the edge that accepts it.
  task automatic send(logic [W-1:0] a, logic [SW-1:0] sh, logic [1:0] md);
    int t = 0;
    in_valid = 1'b1;
    inp      = a;
    diff     = sh;
    mode     = md;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  // Single beat with literal expectations; also pins the model to them.
  task automatic run_one(string nm, logic [W-1:0] a, logic [SW-1:0] sh, logic [1:0] md,
                         logic [W-1:0] en, logic el);
    logic [W:0] m;
    int         lat;
    m = model(a, sh, md);
    chk({nm, "_model"}, 32'(m), 32'({el, en}));
    send(a, sh, md);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(SW));
    chk({nm, "_num"}, 32'(shifted_num), 32'(en));
    chk({nm, "_lost"}, 32'(lost), 32'(el));
    @(posedge clk);
    #1;
  endtask

  localparam logic [W-1:0] Pat = 11'b10010010011;

  initial begin
    int base;
    int t;
    logic [W-1:0]  a;
    logic [SW-1:0] sh;
    logic [1:0]    md;

    in_valid  = 1'b0;
    out_ready = 1'b1;
    inp       = '0;
    diff      = '0;
    mode      = 2'b00;

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_num", 32'(shifted_num), 32'd0);
    chk("reset_lost", 32'(lost), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors
    run_one("rlog",       Pat,   5'd3,  2'b00, 11'b00010010010, 1'b1);
    run_one("sat_rlog",   Pat,   5'd11, 2'b00, 11'b00000000000, 1'b1);
    run_one("sat_zero",   '0,    5'd31, 2'b00, 11'b00000000000, 1'b0);
    run_one("rari",       Pat,   5'd2,  2'b01, 11'b11100100100, 1'b1);
    run_one("llog",       Pat,   5'd4,  2'b10, 11'b00100110000, 1'b1);
    run_one("rsvd_mode",  Pat,   5'd3,  2'b11, 11'b00010010010, 1'b1);
    run_one("zero_shift", Pat,   5'd0,  2'b01, Pat,             1'b0);
    run_one("sat_rari",   Pat,   5'd20, 2'b01, 11'b11111111111, 1'b1);
    run_one("llog_10",    Pat,   5'd10, 2'b10, 11'b10000000000, 1'b1);

    // Streaming: 20 back-to-back random beats with a 3-cycle backpressure hold
    base = n_out;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          a  = W'($urandom);
          sh = SW'($urandom_range(0, 31));
          md = 2'($urandom_range(0, 3));
          if (md == 2'b01 && sh >= SW'(W) && a == '1) a[0] = 1'b0;
          send(a, sh, md);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("hold_in_ready", 32'(in_ready), 32'd0);
          chk("hold_out_valid", 32'(out_valid), 32'd1);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    t = 0;
    while (n_out - base < 20 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("stream_count", 32'(n_out - base), 32'd20);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with beats in flight
    send(Pat, 5'd1, 2'b00);
    send(Pat, 5'd2, 2'b01);
    send(Pat, 5'd3, 2'b10);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_num", 32'(shifted_num), 32'd0);
    chk("midrst_lost", 32'(lost), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = n_out;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_beat", 32'(n_out - base), 32'd0);
    run_one("post_reset", Pat, 5'd3, 2'b00, 11'b00010010010, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
